// File: rtl/dmem_access_ctrl.sv
// Data memory access controller: sequences LOAD, STORE and byte-wise COPY
// requests from the core onto a simple memory port (registered write strobe,
// write address/data, read address, combinational read data) and returns a
// single response per request.
module dmem_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD,
        S_ST,
        S_CRD,
        S_CWR,
        S_RESP
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    state_t              state_q;
    logic [ADDR_W-1:0]   src_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;
    logic                mem_en_q;
    logic [ADDR_W-1:0]   mem_waddr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [ADDR_W-1:0]   mem_raddr_q;

    // Copy bookkeeping derived from the byte counter.
    logic [LEN_W-1:0]    cnt_inc_d;
    logic                copy_last_d;
    logic [ADDR_W-1:0]   dst_cur_d;
    logic [ADDR_W-1:0]   src_nxt_d;
    logic                accept_d;

    assign cnt_inc_d   = cnt_q + LEN_W'(1);
    assign copy_last_d = (cnt_q == (len_q - LEN_W'(1)));
    assign dst_cur_d   = dst_q + ADDR_W'(cnt_q);
    assign src_nxt_d   = src_q + ADDR_W'(cnt_inc_d);
    assign accept_d    = req_valid && (state_q == S_IDLE);

    assign req_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_en         = mem_en_q;
    assign mem_write_addr = mem_waddr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_read_addr  = mem_raddr_q;

    // Controller FSM; every memory-side and response output is registered and
    // set up on the edge that enters the state using it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            mem_raddr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        src_q        <= req_addr;
                        dst_q        <= req_addr2;
                        len_q        <= req_len;
                        cnt_q        <= '0;
                        resp_rdata_q <= '0;
                        resp_err_q   <= 1'b0;
                        case (req_op)
                            OP_LOAD: begin
                                mem_raddr_q <= req_addr;
                                state_q     <= S_LD;
                            end
                            OP_STORE: begin
                                mem_en_q    <= 1'b1;
                                mem_waddr_q <= req_addr;
                                mem_wdata_q <= req_wdata;
                                state_q     <= S_ST;
                            end
                            OP_COPY: begin
                                if (req_len == '0) begin
                                    resp_valid_q <= 1'b1;
                                    state_q      <= S_RESP;
                                end else begin
                                    mem_raddr_q <= req_addr;
                                    state_q     <= S_CRD;
                                end
                            end
                            default: begin
                                resp_err_q   <= 1'b1;
                                resp_valid_q <= 1'b1;
                                state_q      <= S_RESP;
                            end
                        endcase
                    end
                end
                S_LD: begin
                    resp_rdata_q <= mem_read_data;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_ST: begin
                    mem_en_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_CRD: begin
                    // The write-data register doubles as the copied byte holder.
                    mem_wdata_q <= mem_read_data;
                    mem_waddr_q <= dst_cur_d;
                    mem_en_q    <= 1'b1;
                    state_q     <= S_CWR;
                end
                S_CWR: begin
                    mem_en_q <= 1'b0;
                    if (copy_last_d) begin
                        resp_rdata_q <= mem_wdata_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q       <= cnt_inc_d;
                        mem_raddr_q <= src_nxt_d;
                        state_q     <= S_CRD;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed scenarios followed by random requests,
// checked against a request-level memory model.
module tb_dmem_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [7:0] req_addr = 8'h00;
    logic [7:0] req_addr2 = 8'h00;
    logic [7:0] req_wdata = 8'h00;
    logic [7:0] req_len = 8'h00;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [7:0] resp_rdata;
    logic       resp_err;
    logic       busy;
    logic       mem_en;
    logic [7:0] mem_write_addr;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_addr;
    logic [7:0] mem_read_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic       init_done = 1'b0;
    int         cyc = 0;
    logic [7:0] wq_a [$];
    logic [7:0] wq_d [$];
    int         wq_c [$];

    dmem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_addr2(req_addr2), .req_wdata(req_wdata),
        .req_len(req_len),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .mem_en(mem_en), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_read_addr];

    // Memory and write-pulse log: each strobe sampled at the edge ending its cycle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!init_done) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'((a * 37 + 11) & 255);
            init_done <= 1'b1;
        end else if (mem_en) begin
            mem[mem_write_addr] <= mem_write_data;
            wq_a.push_back(mem_write_addr);
            wq_d.push_back(mem_write_data);
            wq_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic check_mem(input string tag);
        int diffs = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) diffs++;
        check(tag, diffs, 0);
    endtask

    // One request end to end; the model predicts the result, latency and writes.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] a2, input logic [7:0] wd,
                          input logic [7:0] len, input int hold);
        logic [7:0] exp_rdata = 8'h00;
        logic       exp_err = 1'b0;
        int         exp_lat;
        logic [7:0] ea [$];
        logic [7:0] ed [$];
        int         ec [$];
        int         acc, wbase, k;
        logic [7:0] b;
        case (op)
            2'b00: begin exp_rdata = ref_mem[a]; exp_lat = 2; end
            2'b01: begin
                ref_mem[a] = wd; exp_lat = 2;
                ea.push_back(a); ed.push_back(wd); ec.push_back(1);
            end
            2'b10: begin
                exp_lat = 1 + 2 * int'(len);
                for (int i = 0; i < int'(len); i++) begin
                    b = ref_mem[8'(a + i)];
                    ref_mem[8'(a2 + i)] = b;
                    ea.push_back(8'(a2 + i)); ed.push_back(b); ec.push_back(2 + 2 * i);
                    exp_rdata = b;
                end
            end
            default: begin exp_err = 1'b1; exp_lat = 1; end
        endcase
        @(negedge clk);
        req_op = op; req_addr = a; req_addr2 = a2; req_wdata = wd; req_len = len;
        req_valid = 1'b1;
        check({tag, ".req_ready"}, req_ready, 1);
        acc = cyc;
        wbase = wq_a.size();
        @(negedge clk);
        req_valid = 1'b0;
        if (op == 2'b00) check({tag, ".rd_addr"}, mem_read_addr, a);
        k = 1;
        while (!resp_valid && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".latency"}, k, exp_lat);
        check({tag, ".rdata"}, resp_rdata, exp_rdata);
        check({tag, ".err"}, resp_err, exp_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, resp_valid, 1);
            check({tag, ".hold_rdata"}, resp_rdata, exp_rdata);
            check({tag, ".hold_ready"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, ".valid_clr"}, resp_valid, 0);
        check({tag, ".idle"}, req_ready, 1);
        check({tag, ".nwrites"}, wq_a.size() - wbase, ea.size());
        for (int i = 0; i < ea.size() && wbase + i < wq_a.size(); i++) begin
            check({tag, ".waddr"}, wq_a[wbase + i], ea[i]);
            check({tag, ".wdata"}, wq_d[wbase + i], ed[i]);
            check({tag, ".wcycle"}, wq_c[wbase + i] - acc, ec[i]);
        end
        check_mem({tag, ".mem"});
        $display("req %s op=%0d a=%02h a2=%02h wd=%02h len=%0d -> rdata=%02h err=%0d lat=%0d",
                 tag, op, a, a2, wd, len, resp_rdata, resp_err, k);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"}, req_ready, 1);
        check({tag, ".resp_valid"}, resp_valid, 0);
        check({tag, ".resp_rdata"}, resp_rdata, 0);
        check({tag, ".resp_err"}, resp_err, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".mem_en"}, mem_en, 0);
        check({tag, ".waddr"}, mem_write_addr, 0);
        check({tag, ".wdata"}, mem_write_data, 0);
        check({tag, ".raddr"}, mem_read_addr, 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'((a * 37 + 11) & 255);
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        do_req("store", 2'b01, 8'h10, 8'h00, 8'hA5, 8'd0, 0);
        do_req("pre20", 2'b01, 8'h20, 8'h00, 8'h3C, 8'd0, 0);
        do_req("load", 2'b00, 8'h20, 8'h00, 8'h00, 8'd0, 3);

        do_req("pre0", 2'b01, 8'h00, 8'h00, 8'h11, 8'd0, 0);
        do_req("pre1", 2'b01, 8'h01, 8'h00, 8'h22, 8'd0, 0);
        do_req("pre2", 2'b01, 8'h02, 8'h00, 8'h33, 8'd0, 0);
        do_req("pre3", 2'b01, 8'h03, 8'h00, 8'h44, 8'd0, 0);
        do_req("copy4", 2'b10, 8'h00, 8'h40, 8'h00, 8'd4, 1);
        check("copy4.m43", mem[8'h43], 8'h44);

        do_req("copywrap", 2'b10, 8'hFE, 8'h10, 8'h00, 8'd3, 0);
        do_req("ov0", 2'b01, 8'h00, 8'h00, 8'h01, 8'd0, 0);
        do_req("ov1", 2'b01, 8'h01, 8'h00, 8'h02, 8'd0, 0);
        do_req("ov2", 2'b01, 8'h02, 8'h00, 8'h03, 8'd0, 0);
        do_req("overlap", 2'b10, 8'h00, 8'h01, 8'h00, 8'd3, 0);
        for (int a = 0; a < 4; a++) check("overlap.byte", mem[a], 8'h01);

        do_req("len0", 2'b10, 8'h30, 8'h50, 8'h00, 8'd0, 0);
        do_req("illegal", 2'b11, 8'h30, 8'h50, 8'h77, 8'd5, 2);

        // Reset during the third write cycle of an 8-byte copy: two bytes land.
        @(negedge clk);
        req_op = 2'b10; req_addr = 8'h80; req_addr2 = 8'h90; req_len = 8'd8;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort.pre_en", mem_en, 1);
        check("abort.pre_waddr", mem_write_addr, 8'h92);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        for (int i = 0; i < 2; i++) ref_mem[8'(8'h90 + i)] = ref_mem[8'(8'h80 + i)];
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_mem("abort.mem");
        do_req("postload", 2'b00, 8'h91, 8'h00, 8'h00, 8'd0, 0);

        for (int n = 0; n < 40; n++) begin
            do_req("rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                   8'($urandom), 8'($urandom_range(0, 10)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so a stuck design still ends the run.
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
